cpu1_instr_issuer: RTL and testbench

CPU1_INSTR_ISSUER -- requirements
Module: cpu1_instr_issuer

---
 rtl/cpu1_instr_issuer.sv | 157 +++++++++++++++
 tb/tb_cpu1_instr_issuer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu1_instr_issuer.sv
`default_nettype none
// ============================================================================
// Module   : cpu1_instr_issuer
// Purpose  : Streams instruction words from a 32x16 program memory to a CPU,
//            following JUMPs, pacing issues, and draining after a HALT.
// Revision : 1.0 - initial release
// ============================================================================
module cpu1_instr_issuer #(
   parameter logic [3:0]  ISSUE_GAP     = 4'd0,
   parameter logic [7:0]  DRAIN_TIMEOUT = 8'd8,
   parameter logic [15:0] MAX_ISSUE     = 16'hFFFF
) (
   input  logic        clk,
   input  logic        pon_rst_n_i,
   input  logic        load_we,
   input  logic [4:0]  load_addr,
   input  logic [15:0] load_data,
   input  logic        start,
   input  logic        cpu_halt,
   output logic [15:0] instruction,
   output logic        instr_valid,
   output logic [4:0]  fetch_ptr,
   output logic [15:0] issued_count,
   output logic        busy,
   output logic        done,
   output logic        timeout
);

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_issue = 3'd1;
   localparam logic [2:0] c_st_gap   = 3'd2;
   localparam logic [2:0] c_st_drain = 3'd3;
   localparam logic [2:0] c_st_done  = 3'd4;

   localparam logic [3:0] c_op_jump  = 4'hD;
   localparam logic [3:0] c_op_halt  = 4'hF;

   logic [15:0] r_mem [32];
   logic [2:0]  r_state;
   logic [15:0] r_instruction;
   logic        r_instr_valid;
   logic [4:0]  r_fetch_ptr;
   logic [15:0] r_issued_count;
   logic        r_timeout;
   logic [7:0]  r_drain_cnt;
   logic [3:0]  r_gap_cnt;

   logic [15:0] w_word;
   logic        w_is_jump;
   logic        w_is_halt;
   logic [4:0]  w_next_ptr;
   logic [15:0] w_count_inc;
   logic        w_limit;
   logic [7:0]  w_drain_inc;
   logic        w_drain_expired;
   logic        w_gap_last;
   logic        w_mem_we;

   assign w_word          = r_mem[r_fetch_ptr];
   assign w_is_jump       = (w_word[15:12] == c_op_jump);
   assign w_is_halt       = (w_word[15:12] == c_op_halt);
   // Sequential fetch relies on 5-bit overflow to wrap 31 -> 0.
   assign w_next_ptr      = w_is_jump ? w_word[4:0] : r_fetch_ptr + 5'd1;
   assign w_count_inc     = (r_issued_count == 16'hFFFF) ? r_issued_count
                                                         : r_issued_count + 16'd1;
   assign w_limit         = (w_count_inc >= MAX_ISSUE);
   assign w_drain_inc     = r_drain_cnt + 8'd1;
   assign w_drain_expired = (w_drain_inc >= DRAIN_TIMEOUT);
   assign w_gap_last      = (r_gap_cnt == ISSUE_GAP - 4'd1);
   assign w_mem_we        = load_we && ((r_state == c_st_idle) || (r_state == c_st_done));

   // Program memory is deliberately outside reset so a program survives it.
   always_ff @(posedge clk) begin
      if (pon_rst_n_i && w_mem_we) begin
         r_mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!pon_rst_n_i) begin
         r_state        <= c_st_idle;
         r_instruction  <= 16'h0000;
         r_instr_valid  <= 1'b0;
         r_fetch_ptr    <= 5'd0;
         r_issued_count <= 16'd0;
         r_timeout      <= 1'b0;
         r_drain_cnt    <= 8'd0;
         r_gap_cnt      <= 4'd0;
      end else begin
         r_instr_valid <= 1'b0;
         case (r_state)
            c_st_idle, c_st_done: begin
               if (start) begin
                  r_state        <= c_st_issue;
                  r_fetch_ptr    <= 5'd0;
                  r_issued_count <= 16'd0;
                  r_timeout      <= 1'b0;
                  r_drain_cnt    <= 8'd0;
               end
            end
            c_st_issue: begin
               if (cpu_halt) begin
                  r_state <= c_st_done;
               end else begin
                  r_instruction  <= w_word;
                  r_instr_valid  <= 1'b1;
                  r_issued_count <= w_count_inc;
                  r_fetch_ptr    <= w_next_ptr;
                  // A HALT takes precedence over hitting the issue limit.
                  if (w_is_halt) begin
                     r_state <= c_st_drain;
                  end else if (w_limit) begin
                     r_state <= c_st_done;
                  end else if (ISSUE_GAP != 4'd0) begin
                     r_state   <= c_st_gap;
                     r_gap_cnt <= 4'd0;
                  end
               end
            end
            c_st_gap: begin
               if (cpu_halt) begin
                  r_state <= c_st_done;
               end else if (w_gap_last) begin
                  r_state <= c_st_issue;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 4'd1;
               end
            end
            c_st_drain: begin
               if (cpu_halt) begin
                  r_state <= c_st_done;
               end else begin
                  r_drain_cnt <= w_drain_inc;
                  if (w_drain_expired) begin
                     r_state   <= c_st_done;
                     r_timeout <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign instruction  = r_instruction;
   assign instr_valid  = r_instr_valid;
   assign fetch_ptr    = r_fetch_ptr;
   assign issued_count = r_issued_count;
   assign timeout      = r_timeout;
   assign busy         = (r_state == c_st_issue) || (r_state == c_st_gap) ||
                         (r_state == c_st_drain);
   assign done         = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_cpu1_instr_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu1_instr_issuer
// Purpose  : Self-checking bench for cpu1_instr_issuer (two parameterisations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu1_instr_issuer;

   localparam int c_a_gap = 0;
   localparam int c_a_dt  = 8;
   localparam int c_b_gap = 3;
   localparam int c_b_dt  = 5;
   localparam int c_b_max = 12;

   logic        clk = 1'b0;
   logic        pon_rst_n_i = 1'b0;
   logic        load_we = 1'b0;
   logic [4:0]  load_addr = 5'd0;
   logic [15:0] load_data = 16'h0;
   logic        start = 1'b0;
   logic        cpu_halt = 1'b0;

   logic [15:0] a_instruction, b_instruction;
   logic        a_instr_valid, b_instr_valid;
   logic [4:0]  a_fetch_ptr, b_fetch_ptr;
   logic [15:0] a_issued_count, b_issued_count;
   logic        a_busy, b_busy, a_done, b_done, a_timeout, b_timeout;

   int n_checks = 0;
   int n_pass   = 0;

   logic [15:0] tb_mem [32];
   logic [15:0] m_word [2][256];
   logic [4:0]  m_ptr  [2][256];

   always #5 clk = ~clk;

   cpu1_instr_issuer dut_a (
      .clk(clk), .pon_rst_n_i(pon_rst_n_i), .load_we(load_we), .load_addr(load_addr),
      .load_data(load_data), .start(start), .cpu_halt(cpu_halt),
      .instruction(a_instruction), .instr_valid(a_instr_valid), .fetch_ptr(a_fetch_ptr),
      .issued_count(a_issued_count), .busy(a_busy), .done(a_done), .timeout(a_timeout)
   );

   cpu1_instr_issuer #(
      .ISSUE_GAP(4'd3), .DRAIN_TIMEOUT(8'd5), .MAX_ISSUE(16'd12)
   ) dut_b (
      .clk(clk), .pon_rst_n_i(pon_rst_n_i), .load_we(load_we), .load_addr(load_addr),
      .load_data(load_data), .start(start), .cpu_halt(cpu_halt),
      .instruction(b_instruction), .instr_valid(b_instr_valid), .fetch_ptr(b_fetch_ptr),
      .issued_count(b_issued_count), .busy(b_busy), .done(b_done), .timeout(b_timeout)
   );

   typedef struct {
      logic        rst_n, we;
      logic [4:0]  addr;
      logic [15:0] data;
      logic        start, halt;
      logic        ev;
      logic [15:0] ei;
      logic [4:0]  ep;
      logic [15:0] ec;
      logic        eb, ed, et;
   } vec_t;

   vec_t tbl [12];

   function automatic vec_t mk(input logic rst_n, input logic we, input logic [4:0] addr,
                               input logic [15:0] data, input logic st, input logic hl,
                               input logic ev, input logic [15:0] ei, input logic [4:0] ep,
                               input logic [15:0] ec, input logic eb, input logic ed,
                               input logic et);
      vec_t v;
      v.rst_n = rst_n; v.we = we; v.addr = addr; v.data = data; v.start = st; v.halt = hl;
      v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec; v.eb = eb; v.ed = ed; v.et = et;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      pon_rst_n_i = 1'b0;
      step();
      pon_rst_n_i = 1'b1;
   endtask

   task automatic load(input logic [4:0] addr, input logic [15:0] data);
      load_we = 1'b1; load_addr = addr; load_data = data;
      step();
      load_we = 1'b0;
      tb_mem[addr] = data;
   endtask

   // Walks the program the way the CPU stream should see it: follow JUMPs,
   // stop after a HALT or once the issue limit is reached.
   task automatic model_walk(input int k, input int limit, output int n, output bit halted);
      int p;
      logic [15:0] w;
      p = 0; n = 0; halted = 1'b0;
      while (n < limit && n < 256) begin
         w = tb_mem[p];
         m_word[k][n] = w;
         p = (w[15:12] == 4'hD) ? int'(w[4:0]) : (p + 1) % 32;
         m_ptr[k][n] = 5'(p);
         n++;
         if (w[15:12] == 4'hF) begin
            halted = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_program();
      int na, nb, ia, ib, ta_last, tb_last, ta_done, tb_done;
      bit ha, hb;
      model_walk(0, 200, na, ha);
      model_walk(1, c_b_max, nb, hb);
      ia = 0; ib = 0; ta_last = 0; tb_last = 0; ta_done = -1; tb_done = -1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("a_start_count", a_issued_count, 0);
      chk("a_start_timeout", a_timeout, 0);
      chk("a_start_busy", a_busy, 1);
      chk("b_start_busy", b_busy, 1);
      for (int t = 1; t <= 150 && !(ta_done >= 0 && tb_done >= 0); t++) begin
         // Writes and start pulses while both runs are active must be ignored.
         if (a_busy && b_busy) begin
            load_we = 1'b1; load_addr = 5'($urandom); load_data = 16'($urandom);
            start = 1'($urandom_range(0, 1));
         end else begin
            load_we = 1'b0; start = 1'b0;
         end
         step();
         if (a_instr_valid) begin
            if (ia < na) begin
               chk($sformatf("a_word%0d", ia), a_instruction, m_word[0][ia]);
               chk($sformatf("a_ptr%0d", ia), a_fetch_ptr, m_ptr[0][ia]);
               chk($sformatf("a_count%0d", ia), a_issued_count, ia + 1);
               chk($sformatf("a_time%0d", ia), t, 1 + ia * (c_a_gap + 1));
            end else chk("a_extra_valid", ia, na);
            ia++; ta_last = t;
         end
         if (b_instr_valid) begin
            if (ib < nb) begin
               chk($sformatf("b_word%0d", ib), b_instruction, m_word[1][ib]);
               chk($sformatf("b_ptr%0d", ib), b_fetch_ptr, m_ptr[1][ib]);
               chk($sformatf("b_count%0d", ib), b_issued_count, ib + 1);
               chk($sformatf("b_time%0d", ib), t, 1 + ib * (c_b_gap + 1));
            end else chk("b_extra_valid", ib, nb);
            ib++; tb_last = t;
         end
         if (a_done && ta_done < 0) ta_done = t;
         if (b_done && tb_done < 0) tb_done = t;
      end
      load_we = 1'b0; start = 1'b0;
      chk("a_num_issued", ia, na);
      chk("b_num_issued", ib, nb);
      chk("a_done_time", ta_done, ta_last + (ha ? c_a_dt : 0));
      chk("b_done_time", tb_done, tb_last + (hb ? c_b_dt : 0));
      chk("a_timeout", a_timeout, ha);
      chk("b_timeout", b_timeout, hb);
      chk("a_final_count", a_issued_count, na);
      chk("b_final_count", b_issued_count, nb);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_a_valid"}, a_instr_valid, 0);
      chk({tag, "_a_instr"}, a_instruction, 0);
      chk({tag, "_a_ptr"}, a_fetch_ptr, 0);
      chk({tag, "_a_count"}, a_issued_count, 0);
      chk({tag, "_a_busy"}, a_busy, 0);
      chk({tag, "_a_done"}, a_done, 0);
      chk({tag, "_a_timeout"}, a_timeout, 0);
      chk({tag, "_b_busy"}, b_busy, 0);
      chk({tag, "_b_count"}, b_issued_count, 0);
      chk({tag, "_b_timeout"}, b_timeout, 0);
   endtask

   initial begin
      int na;
      bit ha;

      // Cycle-by-cycle vectors for the basic 3-instruction program on dut_a.
      tbl[0]  = mk(0,0,0,16'h0000, 0,0, 0,16'h0000,0,0, 0,0,0);
      tbl[1]  = mk(1,1,0,16'h4101, 0,0, 0,16'h0000,0,0, 0,0,0);
      tbl[2]  = mk(1,1,1,16'h4203, 0,0, 0,16'h0000,0,0, 0,0,0);
      tbl[3]  = mk(1,1,2,16'hF000, 0,0, 0,16'h0000,0,0, 0,0,0);
      tbl[4]  = mk(1,0,0,16'h0000, 1,0, 0,16'h0000,0,0, 1,0,0);
      tbl[5]  = mk(1,0,0,16'h0000, 0,0, 1,16'h4101,1,1, 1,0,0);
      tbl[6]  = mk(1,0,0,16'h0000, 0,0, 1,16'h4203,2,2, 1,0,0);
      tbl[7]  = mk(1,0,0,16'h0000, 0,0, 1,16'hF000,3,3, 1,0,0);
      tbl[8]  = mk(1,0,0,16'h0000, 0,0, 0,16'hF000,3,3, 1,0,0);
      tbl[9]  = mk(1,0,0,16'h0000, 0,1, 0,16'hF000,3,3, 0,1,0);
      tbl[10] = mk(1,1,3,16'h1234, 0,0, 0,16'hF000,3,3, 0,1,0);
      tbl[11] = mk(0,0,0,16'h0000, 0,0, 0,16'h0000,0,0, 0,0,0);

      for (int i = 0; i < 12; i++) begin
         pon_rst_n_i = tbl[i].rst_n; load_we = tbl[i].we; load_addr = tbl[i].addr;
         load_data = tbl[i].data; start = tbl[i].start; cpu_halt = tbl[i].halt;
         if (tbl[i].rst_n && tbl[i].we) tb_mem[tbl[i].addr] = tbl[i].data;
         step();
         chk($sformatf("row%0d_valid", i), a_instr_valid, tbl[i].ev);
         chk($sformatf("row%0d_instr", i), a_instruction, tbl[i].ei);
         chk($sformatf("row%0d_ptr", i), a_fetch_ptr, tbl[i].ep);
         chk($sformatf("row%0d_count", i), a_issued_count, tbl[i].ec);
         chk($sformatf("row%0d_busy", i), a_busy, tbl[i].eb);
         chk($sformatf("row%0d_done", i), a_done, tbl[i].ed);
         chk($sformatf("row%0d_timeout", i), a_timeout, tbl[i].et);
      end
      pon_rst_n_i = 1'b1; load_we = 1'b0; start = 1'b0; cpu_halt = 1'b0;

      // JUMP forward: 0 -> 5 -> HALT.
      do_reset();
      load(0, 16'hD005);
      load(5, 16'hF000);
      run_program();

      // JUMP to 31 then sequential wrap to 0; cpu_halt in ISSUE/GAP stops without issuing.
      do_reset();
      load(0, 16'hD01F);
      load(31, 16'h0000);
      start = 1'b1; step(); start = 1'b0;
      step();
      chk("wrap_jump_ptr", a_fetch_ptr, 31);
      step();
      chk("wrap_instr", a_instruction, 16'h0000);
      chk("wrap_ptr", a_fetch_ptr, 0);
      cpu_halt = 1'b1;
      step();
      cpu_halt = 1'b0;
      chk("halt_issue_valid", a_instr_valid, 0);
      chk("halt_issue_done", a_done, 1);
      chk("halt_issue_count", a_issued_count, 2);
      chk("halt_gap_done", b_done, 1);
      chk("halt_gap_count", b_issued_count, 1);

      // Four NOPs then HALT: spacing 1 on dut_a, 4 on dut_b.
      do_reset();
      for (int i = 0; i < 4; i++) load(5'(i), 16'h0000);
      load(4, 16'hF000);
      run_program();

      // HALT with no cpu_halt: drain timeout; writes during DRAIN must not land.
      do_reset();
      load(0, 16'hF000);
      run_program();
      run_program();
      do_reset();
      chk("timeout_reset", a_timeout, 0);

      // Reset in the middle of ISSUE, then rerun from retained memory.
      for (int i = 0; i < 4; i++) load(5'(i), 16'h0000);
      load(4, 16'hF000);
      start = 1'b1; step(); start = 1'b0;
      step(); step();
      chk("mid_issue_valid", a_instr_valid, 1);
      pon_rst_n_i = 1'b0;
      step();
      pon_rst_n_i = 1'b1;
      chk_reset_outputs("midrst");
      run_program();

      // Random programs that are guaranteed to reach HALT on the unlimited instance.
      for (int r = 0; r < 6; r++) begin
         do begin
            for (int i = 0; i < 32; i++) begin
               int s;
               s = $urandom_range(0, 15);
               if (s < 2)      tb_mem[i] = {4'hF, 12'($urandom)};
               else if (s < 5) tb_mem[i] = {4'hD, 12'($urandom)};
               else            tb_mem[i] = {4'($urandom_range(0, 12)), 12'($urandom)};
            end
            model_walk(0, 60, na, ha);
         end while (!ha);
         do_reset();
         for (int i = 0; i < 32; i++) load(5'(i), tb_mem[i]);
         run_program();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
